// File: rtl/dmem_pkg.sv
// Shared decode constants and request view for the data-memory responder.
package dmem_pkg;
  localparam int MMIO_SEL_BIT = 31;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_CYCLES = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef struct packed {
    logic       mmio;
    logic [1:0] off;
    logic       wr;
  } dmem_req_t;

  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty);
    logic [31:0] s;
    s           = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_OVF]   = ovf;
    return s;
  endfunction
endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Synchronous TX FIFO; a push into a full FIFO lands only when the same edge pops.
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = store[rd_ptr];

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM below bit 31, MMIO window (TX FIFO, cycle counter, status) above.
// Build option DMEM_CYCLE_COUNTER_EN adds the free-running CYCLES register.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dmem_req_t             req;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [31:0]           rd_word, cycles;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, push, pop, overflow;
  logic                  unused_addr;

  assign req         = '{mmio: address_dmem[MMIO_SEL_BIT], off: address_dmem[1:0], wr: wren};
  assign ram_idx     = address_dmem[ADDR_WIDTH-1:0];
  assign unused_addr = ^address_dmem[30:ADDR_WIDTH];

  assign push     = req.mmio & req.wr & (req.off == OFF_TXDATA);
  assign tx_valid = ~fifo_empty;
  assign pop      = tx_valid & tx_ready;

  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (data),
    .pop   (pop),
    .head  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A store coinciding with reset must not reach the array.
  always_ff @(posedge clock) begin
    if (!reset && req.wr && !req.mmio) mem[ram_idx] <= data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      overflow <= 1'b0;
    else if (req.mmio && req.wr && req.off == OFF_STATUS)
      overflow <= 1'b0;
    else if (push && fifo_full && !pop)
      overflow <= 1'b1;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cycles <= '0;
    else if (req.mmio && req.wr && req.off == OFF_CYCLES)
      cycles <= '0;
    else
      cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif

  always_comb begin
    rd_word = '0;
    if (!req.mmio) begin
      rd_word = mem[ram_idx];
    end else begin
      case (req.off)
        OFF_TXDATA: rd_word = {{(32-CW){1'b0}}, fifo_count};
        OFF_CYCLES: rd_word = cycles;
        OFF_STATUS: rd_word = status_word(overflow, fifo_full, fifo_empty);
        default:    rd_word = '0;
      endcase
    end
  end

  // Registered read; MMIO reads therefore see state from before this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_dmem <= '0;
    else       q_dmem <= rd_word;
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized bench for dmem_mmio_responder against a queue/array reference model.
module tb_dmem_mmio_responder;
  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int WORDS = 2**AW;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem, data;
  logic        wren, tx_ready;
  logic [31:0] q_dmem, tx_data;
  logic        tx_valid;

  dmem_mmio_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [31:0] m_mem [WORDS];
  bit          m_known [WORDS];
  logic [31:0] m_fifo [$];
  logic [31:0] m_cyc;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_cyc = 0;
    m_ovf = 0;
  endtask

  // One clock: drive at negedge, check FIFO head, predict read, advance model, check q_dmem.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    logic [31:0] exp_q;
    bit          known, pop, full;
    int          idx;
    @(negedge clock);
    reset = 1'b0;
    address_dmem = a; data = d; wren = w; tx_ready = r;
    #1;
    chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_fifo.size() > 0});
    if (m_fifo.size() > 0) chk("tx_data", tx_data, m_fifo[0]);

    idx   = int'(a % WORDS);
    full  = (m_fifo.size() == DEPTH);
    known = 1;
    exp_q = 0;
    if (!a[31]) begin
      exp_q = m_mem[idx];
      known = m_known[idx];
    end else begin
      case (a[1:0])
        2'd0: exp_q = m_fifo.size();
`ifdef DMEM_CYCLE_COUNTER_EN
        2'd1: exp_q = m_cyc;
`endif
        2'd2: exp_q = {29'b0, m_ovf, full, m_fifo.size() == 0};
        default: exp_q = 0;
      endcase
    end

    pop = (m_fifo.size() > 0) && r;
    if (pop) void'(m_fifo.pop_front());
    if (!a[31] && w) begin
      m_mem[idx]   = d;
      m_known[idx] = 1;
    end
    if (a[31] && w && a[1:0] == 2'd0) begin
      if (full && !pop) m_ovf = 1;
      else m_fifo.push_back(d);
    end
    if (a[31] && w && a[1:0] == 2'd2) m_ovf = 0;
    if (a[31] && w && a[1:0] == 2'd1) m_cyc = 0;
    else m_cyc = m_cyc + 1;

    @(posedge clock);
    #1;
    if (known) chk("q_dmem", q_dmem, exp_q);
  endtask

  // Async reset asserted in the middle of a cycle while a RAM store is presented.
  task automatic pulse_reset(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    address_dmem = a; data = d; wren = 1'b1; tx_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_q_dmem", q_dmem, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    address_dmem = 0; data = 0; wren = 0; tx_ready = 0;
    for (int i = 0; i < WORDS; i++) m_known[i] = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("init_q_dmem", q_dmem, 32'd0);
    chk("init_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("init_tx_data", tx_data, 32'd0);

    // RAM store/load and address wrap
    step(32'd5, 32'h1234_ABCD, 1, 0);
    step(32'd5, 32'h0, 0, 0);
    step(32'd5 + WORDS, 32'h0, 0, 0);
    chk("ram_wrap", q_dmem, 32'h1234_ABCD);

    // Fill past full with sink stalled, then drain
    for (int i = 1; i <= 9; i++) step(32'h8000_0000, i, 1, 0);
    step(32'h8000_0000, 0, 0, 0);
    chk("count_full", q_dmem, 32'd8);
    step(32'h8000_0002, 0, 0, 0);
    chk("status_full_ovf", q_dmem, 32'b110);
    for (int i = 0; i < 8; i++) step(32'h8000_0002, 0, 0, 1);
    step(32'h8000_0002, 0, 0, 0);
    chk("status_empty_ovf", q_dmem, 32'b101);
    step(32'h8000_0002, 0, 1, 0);

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) step(32'h8000_0000, 32'h100 + i, 1, 0);
    step(32'h8000_0000, 32'hAA, 1, 1);
    step(32'h8000_0002, 0, 0, 0);
    chk("status_pushpop_full", q_dmem, 32'b010);
    for (int i = 0; i < 9; i++) step(32'h8000_0000, 0, 0, 1);

    // Cycle counter after reset, then clear
    pulse_reset(32'd7, 32'h5555_5555);
    for (int i = 0; i < 10; i++) step(32'd5, 0, 0, 0);
    step(32'h8000_0001, 0, 0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
    chk("cycles_10", q_dmem, 32'd10);
`else
    chk("cycles_off", q_dmem, 32'd0);
`endif
    step(32'h8000_0001, 32'hFFFF, 1, 0);
    step(32'h8000_0001, 0, 0, 0);
    step(32'h8000_0001, 0, 0, 0);

    // Reset with entries queued and a RAM store presented
    for (int i = 0; i < 3; i++) step(32'h8000_0000, 32'h300 + i, 1, 0);
    pulse_reset(32'd5, 32'hDEAD_BEEF);
    step(32'h8000_0002, 0, 0, 0);
    chk("status_after_rst", q_dmem, 32'b001);
    step(32'd5, 0, 0, 0);
    chk("ram_store_lost", q_dmem, 32'h1234_ABCD);

    // Overflow clear via STATUS write, offset 3 reads zero
    for (int i = 0; i < 9; i++) step(32'h8000_0000, 32'h400 + i, 1, 0);
    step(32'h8000_0002, 0, 0, 0);
    step(32'h8000_0002, 32'h0, 1, 0);
    step(32'h8000_0002, 0, 0, 0);
    chk("status_ovf_cleared", q_dmem, 32'b010);
    step(32'h8000_0003, 32'hFFFF_FFFF, 1, 0);
    step(32'h8000_0003, 0, 0, 0);
    chk("off3_zero", q_dmem, 32'd0);
    for (int i = 0; i < 9; i++) step(32'h8000_0000, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) a = a + ($urandom_range(1, 7) << AW);
      end else begin
        a = 32'h8000_0000 | $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'h7FFF_FFFC);
      end
      step(a, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
